tm1637_frame_driver: RTL and testbench
======================================

Name: tm1637_frame_driver

Overview:
- Serial frame engine for the TM1637 4-digit LED driver.
- Consumes the divided square-wave clock produced by the clock divider stage and uses each of its rising edges as one protocol tick.
- Emits a full display update on the two TM1637 pins: data command, address command plus digit bytes, display-control command.
- Sits between the digit/segment encoder (upstream, supplies bytes) and the board pins (downstream).

Parameters:
- NUM_DIGITS, 4: segment bytes sent per frame.
- CMD_DATA, 8'h40: data command (write, auto-increment).
- CMD_ADDR, 8'hC0: address command (start at grid 0).
- CMD_DISP, 8'h88: display control base (display on); brightness ORed into bits [2:0].

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous reset, active-high.
- i_div_clk  input  1  divided square wave from clock divider, generated in the i_clk domain.
- i_start  input  1  request one frame; accepted only when o_busy=0.
- i_data  input  8*NUM_DIGITS  segment bytes; digit 0 = [7:0], sent first.
- i_bright  input  3  brightness level 0..7.
- i_tm_dio  input  1  DIO pin read-back, used for ACK sampling.
- o_tm_clk  output  1  TM1637 CLK pin, push-pull.
- o_tm_dio_oe  output  1  1 = drive DIO low; 0 = release (pull-up gives high).
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse at frame end.
- o_nack  output  1  at least one missing ACK in the current/last frame.

Behaviour:
- Reset values (registered): o_tm_clk=1, o_tm_dio_oe=0, o_busy=0, o_done=0, o_nack=0, state IDLE.
- Reset mid-frame: all outputs return to reset values on the next edge; no stop condition is generated. The next frame's START resynchronises the device.
- Tick generation:
  - Register i_div_clk; tick = i_div_clk & ~prev.
  - This gives exactly one i_clk-cycle pulse per divider rising edge.
  - All pin changes happen only on tick cycles.
- Accept:
  - i_start with o_busy=0 latches i_data and i_bright and sets o_busy next cycle.
  - i_start while busy is ignored.
  - The first protocol action occurs on the first tick strictly after the accept cycle, even if a tick coincides with the accept cycle.
- Segment structure: three segments back to back.
  - Segment 1: START, CMD_DATA, STOP.
  - Segment 2: START, CMD_ADDR, digit0..digit(N-1), STOP.
  - Segment 3: START, CMD_DISP|i_bright, STOP.
- START, 1 tick: DIO driven low (oe=1) while CLK=1.
- Data bit, 3 ticks, LSB first:
  - p0: CLK<=0.
  - p1: oe<=~bit.
  - p2: CLK<=1.
- ACK, 4 ticks:
  - p0: CLK<=0.
  - p1: oe<=0.
  - p2: CLK<=1.
  - p3: sample i_tm_dio with CLK high; if 1, set o_nack.
  - Byte total = 28 ticks.
- STOP, 3 ticks:
  - s0: CLK<=0, oe<=1.
  - s1: CLK<=1.
  - s2: oe<=0.
- Pin invariant: DIO changes only while CLK=0, except at START and STOP edges.
- Frame length: 68 + 28*(1+NUM_DIGITS) ticks (208 for NUM_DIGITS=4).
- End of frame:
  - On the cycle after the final STOP tick: o_done=1 for one cycle and o_busy=0.
  - i_start on that same cycle is accepted.
- o_nack is cleared on accept and holds its value after o_done until the next accept.
- No ticks (divider stalled): state and pins hold indefinitely.
- State machine: IDLE, START, BIT, ACK, STOP, DONE.
  - A segment counter (0..2) and a byte index select the byte being sent.
  - A bit counter 0..7 and a phase counter 0..3 track position within the byte.

Test Plan:
- Reset: assert i_rst for 3 cycles with i_div_clk toggling. Required: o_tm_clk=1, oe=0, busy=0, done=0, nack=0; pins unchanged.
- Nominal frame: i_data=32'h4F5B063F, i_bright=3'd7, bench TM1637 model pulls DIO low in every ACK p3. Required:
  - decoded bytes 40, C0, 3F, 06, 5B, 4F, 8F;
  - o_done exactly 208 ticks after accept;
  - o_nack=0.
- NACK: model never ACKs (i_tm_dio=1). Required: the full 208-tick frame still completes and o_nack=1 after o_done.
- Handshake:
  - i_start pulsed at tick 50 of a frame: ignored, data unchanged.
  - i_start on the o_done cycle with new data: second frame starts, back-to-back, correct bytes.
- Reset mid-frame at tick 100: outputs reach idle on the next cycle. A new start then yields a correct 208-tick frame.
- Protocol checker on all frames: DIO never changes while CLK=1 except START/STOP; no pin change on a non-tick cycle; divider held low for 500 cycles freezes all pins.

Source files
------------

// File: rtl/tm1637_frame_driver.sv
// -----------------------------------------------------------------------------
// tm1637_frame_driver
//
// Serial frame engine for a TM1637 4-digit LED driver. Each rising edge of the
// divided clock (i_div_clk) is one protocol tick. A frame is three segments
// sent back to back:
//   1) START, CMD_DATA, STOP
//   2) START, CMD_ADDR, digit0 .. digit(N-1), STOP
//   3) START, CMD_DISP | brightness, STOP
// Bytes go out LSB first. Each byte is 8 data bits (3 ticks each) followed by
// an ACK slot (4 ticks), so one byte is 28 ticks. A frame is
// 68 + 28*(1+NUM_DIGITS) ticks long.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_div_clk    divided square wave from the clock divider (i_clk domain)
//   i_start      frame request; accepted only while o_busy = 0
//   i_data       segment bytes; digit 0 = [7:0] and is sent first
//   i_bright     brightness 0..7, ORed into CMD_DISP[2:0]
//   i_tm_dio     DIO pin read-back, sampled in the ACK slot
//   o_tm_clk     TM1637 CLK pin (push-pull)
//   o_tm_dio_oe  1 = pull DIO low, 0 = release (external pull-up)
//   o_busy       frame in progress
//   o_done       one-cycle pulse when a frame completes
//   o_nack       at least one missing ACK in the current/last frame
// -----------------------------------------------------------------------------
module tm1637_frame_driver #(
    parameter int         NUM_DIGITS = 4,
    parameter logic [7:0] CMD_DATA   = 8'h40,
    parameter logic [7:0] CMD_ADDR   = 8'hC0,
    parameter logic [7:0] CMD_DISP   = 8'h88
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_div_clk,
    input  logic                    i_start,
    input  logic [8*NUM_DIGITS-1:0] i_data,
    input  logic [2:0]              i_bright,
    input  logic                    i_tm_dio,
    output logic                    o_tm_clk,
    output logic                    o_tm_dio_oe,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_nack
);

    // Byte index within a segment runs 0..NUM_DIGITS (address byte + digits).
    localparam int IDX_W = (NUM_DIGITS < 1) ? 1 : $clog2(NUM_DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic                      r_div_prev;
    logic [1:0]                r_seg;
    logic [IDX_W-1:0]          r_byte_idx;
    logic [2:0]                r_bit;
    logic [1:0]                r_phase;
    logic [8*NUM_DIGITS-1:0]   r_data;
    logic [2:0]                r_bright;

    logic                      w_tick;
    logic                      w_accept;
    logic [7:0]                w_digit;
    logic [7:0]                w_byte;
    logic                      w_last_byte;

    // One i_clk-wide pulse per rising edge of the divided clock. The history
    // register tracks the divider continuously, reset or not, so leaving
    // reset while the divider is high never fakes an edge.
    always_ff @(posedge i_clk) begin
        r_div_prev <= i_div_clk;
    end

    assign w_tick   = i_div_clk & ~r_div_prev;
    assign w_accept = i_start & ~o_busy;

    // Frame payload is captured at accept so upstream may change i_data
    // freely while the frame is on the wire.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_data   <= i_data;
            r_bright <= i_bright;
        end
    end

    // Digit byte for the address segment; index 0 is the address command,
    // so digit k sits at index k+1.
    always_comb begin
        w_digit = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_byte_idx == IDX_W'(i + 1)) begin
                w_digit = r_data[8*i +: 8];
            end
        end
    end

    // Byte currently being shifted out and whether it closes its segment.
    always_comb begin
        w_byte      = CMD_DATA;
        w_last_byte = 1'b1;
        case (r_seg)
            2'd0: begin
                w_byte      = CMD_DATA;
                w_last_byte = 1'b1;
            end
            2'd1: begin
                w_byte      = (r_byte_idx == '0) ? CMD_ADDR : w_digit;
                w_last_byte = (r_byte_idx == IDX_W'(NUM_DIGITS));
            end
            default: begin
                w_byte      = CMD_DISP | {5'b00000, r_bright};
                w_last_byte = 1'b1;
            end
        endcase
    end

    // Protocol state machine. Outside IDLE/DONE nothing moves unless w_tick
    // is high, so a stalled divider freezes pins and state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            o_tm_clk    <= 1'b1;
            o_tm_dio_oe <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_nack      <= 1'b0;
            r_seg       <= 2'd0;
            r_byte_idx  <= '0;
            r_bit       <= 3'd0;
            r_phase     <= 2'd0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                // DONE is the single cycle that carries o_done; a start
                // request there is accepted exactly like in IDLE.
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state    <= S_START;
                        o_busy     <= 1'b1;
                        o_nack     <= 1'b0;
                        r_seg      <= 2'd0;
                        r_byte_idx <= '0;
                        r_bit      <= 3'd0;
                        r_phase    <= 2'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                // START: DIO falls while CLK is high.
                S_START: begin
                    if (w_tick) begin
                        o_tm_dio_oe <= 1'b1;
                        r_state     <= S_BIT;
                        r_bit       <= 3'd0;
                        r_phase     <= 2'd0;
                    end
                end

                // Data bit: CLK low, set DIO, CLK high (device latches).
                S_BIT: begin
                    if (w_tick) begin
                        case (r_phase)
                            2'd0: begin
                                o_tm_clk <= 1'b0;
                                r_phase  <= 2'd1;
                            end
                            2'd1: begin
                                o_tm_dio_oe <= ~w_byte[r_bit];
                                r_phase     <= 2'd2;
                            end
                            default: begin
                                o_tm_clk <= 1'b1;
                                r_phase  <= 2'd0;
                                if (r_bit == 3'd7) begin
                                    r_state <= S_ACK;
                                end else begin
                                    r_bit <= r_bit + 3'd1;
                                end
                            end
                        endcase
                    end
                end

                // ACK: release DIO while CLK is low, raise CLK, then sample.
                // The device answers by holding DIO low; a high reads as NACK.
                S_ACK: begin
                    if (w_tick) begin
                        case (r_phase)
                            2'd0: begin
                                o_tm_clk <= 1'b0;
                                r_phase  <= 2'd1;
                            end
                            2'd1: begin
                                o_tm_dio_oe <= 1'b0;
                                r_phase     <= 2'd2;
                            end
                            2'd2: begin
                                o_tm_clk <= 1'b1;
                                r_phase  <= 2'd3;
                            end
                            default: begin
                                if (i_tm_dio) begin
                                    o_nack <= 1'b1;
                                end
                                r_phase <= 2'd0;
                                r_bit   <= 3'd0;
                                if (w_last_byte) begin
                                    r_state <= S_STOP;
                                end else begin
                                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                                    r_state    <= S_BIT;
                                end
                            end
                        endcase
                    end
                end

                // STOP: DIO low under CLK low, CLK high, then DIO rises
                // while CLK is high.
                S_STOP: begin
                    if (w_tick) begin
                        case (r_phase)
                            2'd0: begin
                                o_tm_clk    <= 1'b0;
                                o_tm_dio_oe <= 1'b1;
                                r_phase     <= 2'd1;
                            end
                            2'd1: begin
                                o_tm_clk <= 1'b1;
                                r_phase  <= 2'd2;
                            end
                            default: begin
                                o_tm_dio_oe <= 1'b0;
                                r_phase     <= 2'd0;
                                r_byte_idx  <= '0;
                                if (r_seg == 2'd2) begin
                                    r_state <= S_DONE;
                                    o_done  <= 1'b1;
                                    o_busy  <= 1'b0;
                                end else begin
                                    r_seg   <= r_seg + 2'd1;
                                    r_state <= S_START;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1637_frame_driver.sv
module tb_tm1637_frame_driver;

    localparam int ND          = 4;
    localparam int NBYTES      = ND + 3;
    localparam int FRAME_TICKS = 68 + 28 * (1 + ND);

    logic          clk = 1'b0;
    logic          rst;
    logic          div_clk;
    logic          start;
    logic [8*ND-1:0] data;
    logic [2:0]    bright;
    logic          tm_dio;
    logic          tm_clk;
    logic          dio_oe;
    logic          busy;
    logic          done;
    logic          nack;

    always #5 clk = ~clk;

    tm1637_frame_driver #(
        .NUM_DIGITS (ND),
        .CMD_DATA   (8'h40),
        .CMD_ADDR   (8'hC0),
        .CMD_DISP   (8'h88)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_div_clk   (div_clk),
        .i_start     (start),
        .i_data      (data),
        .i_bright    (bright),
        .i_tm_dio    (tm_dio),
        .o_tm_clk    (tm_clk),
        .o_tm_dio_oe (dio_oe),
        .o_busy      (busy),
        .o_done      (done),
        .o_nack      (nack)
    );

    int errors = 0;
    int checks = 0;

    // divider generator
    logic div_last;
    bit   div_run;
    int   half_len;
    int   half_cnt;
    int   tick_cnt;
    int   t0;

    // bus-level TM1637 device model
    bit         p_clk;
    bit         p_oe;
    bit         p_dio;
    bit         dev_pull;
    bit         in_frame;
    int         rise_cnt;
    logic [7:0] shreg;
    logic [7:0] got[$];
    int         n_start;
    int         n_stop;
    logic [6:0] ack_mask;

    // reference for the frame in flight
    logic [7:0] exp_b[NBYTES];
    logic       exp_nack;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One i_clk cycle: observe pins at the falling edge, run the device
    // model and protocol checks, then set up the divider for the next edge.
    task automatic cycle();
        bit tick_now;
        bit rst_now;
        bit dio_now;
        bit clk_rise;
        bit clk_fall;
        @(negedge clk);
        tick_now = div_clk && !div_last;
        div_last = div_clk;
        rst_now  = rst;
        if (tick_now) tick_cnt++;

        if (tm_clk !== p_clk || dio_oe !== p_oe)
            check("pin_change_on_tick", {63'd0, tick_now || rst_now}, 64'd1);

        dio_now = !dio_oe && !dev_pull;
        if (rst_now) begin
            in_frame = 1'b0;
            rise_cnt = 0;
            dev_pull = 1'b0;
        end else begin
            if (p_clk && tm_clk && (dio_now != p_dio)) begin
                if (!dio_now) begin
                    n_start++;
                    check("start_aligned", rise_cnt, 0);
                    in_frame = 1'b1;
                    rise_cnt = 0;
                end else begin
                    n_stop++;
                    check("stop_aligned", rise_cnt, 1);
                    in_frame = 1'b0;
                    rise_cnt = 0;
                end
            end
            clk_rise = tm_clk && !p_clk;
            clk_fall = !tm_clk && p_clk;
            if (clk_rise && in_frame) begin
                rise_cnt++;
                if (rise_cnt <= 8) shreg = {dio_now, shreg[7:1]};
                if (rise_cnt == 8) got.push_back(shreg);
                if (rise_cnt == 9) rise_cnt = 0;
            end
            if (clk_fall)
                dev_pull = (rise_cnt == 8) && (got.size() <= 7) && (ack_mask[got.size() - 1] == 1'b1);
        end

        tm_dio = !dio_oe && !dev_pull;
        p_clk  = tm_clk;
        p_oe   = dio_oe;
        p_dio  = !dio_oe && !dev_pull;

        if (!div_run) begin
            div_clk  = 1'b0;
            half_cnt = 0;
        end else begin
            half_cnt++;
            if (half_cnt >= half_len) begin
                div_clk  = ~div_clk;
                half_cnt = 0;
                half_len = $urandom_range(1, 3);
            end
        end
    endtask

    task automatic start_frame(input logic [8*ND-1:0] d, input logic [2:0] b, input logic [6:0] mask);
        data     = d;
        bright   = b;
        ack_mask = mask;
        start    = 1'b1;
        exp_b[0] = 8'h40;
        exp_b[1] = 8'hC0;
        for (int i = 0; i < ND; i++) exp_b[2 + i] = d[8*i +: 8];
        exp_b[NBYTES - 1] = 8'h88 | {5'd0, b};
        exp_nack = (mask != 7'h7F);
        cycle();
        start = 1'b0;
        t0 = tick_cnt;
        got.delete();
        n_start = 0;
        n_stop  = 0;
        check("accept_busy", busy, 1);
        check("accept_done_low", done, 0);
        check("accept_nack_clear", nack, 0);
        check("accept_pins_idle", {tm_clk, dio_oe}, 2'b10);
    endtask

    task automatic run_to_tick(input int k);
        int n = 0;
        while ((tick_cnt - t0) < k && n < 2000) begin
            cycle();
            n++;
        end
        check("run_to_tick_reached", tick_cnt - t0, k);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4000) begin
            cycle();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_ticks"}, tick_cnt - t0, FRAME_TICKS);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_nack"}, nack, exp_nack);
        check({tag, "_starts"}, n_start, 3);
        check({tag, "_stops"}, n_stop, 3);
        check({tag, "_nbytes"}, got.size(), NBYTES);
        for (int i = 0; i < NBYTES; i++)
            check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, exp_b[i]);
    endtask

    initial begin
        logic hold_clk;
        logic hold_oe;

        rst      = 1'b1;
        start    = 1'b0;
        data     = '0;
        bright   = 3'd0;
        div_clk  = 1'b0;
        div_last = 1'b0;
        div_run  = 1'b1;
        half_len = 2;
        half_cnt = 0;
        tick_cnt = 0;
        t0       = 0;
        p_clk    = 1'b1;
        p_oe     = 1'b0;
        p_dio    = 1'b1;
        dev_pull = 1'b0;
        in_frame = 1'b0;
        rise_cnt = 0;
        shreg    = 8'h00;
        n_start  = 0;
        n_stop   = 0;
        ack_mask = 7'h7F;
        tm_dio   = 1'b1;

        // reset with the divider running
        repeat (3) begin
            cycle();
            check("rst_clk", tm_clk, 1);
            check("rst_oe", dio_oe, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_nack", nack, 0);
        end
        rst = 1'b0;
        repeat (6) cycle();
        check("idle_pins", {tm_clk, dio_oe, busy}, 3'b100);

        // nominal frame
        start_frame(32'h4F5B063F, 3'd7, 7'h7F);
        wait_done("nom");

        // device never acknowledges
        repeat (3) cycle();
        start_frame($urandom, 3'($urandom_range(0, 7)), 7'h00);
        wait_done("nack");
        repeat (5) cycle();
        check("nack_hold", nack, 1);
        check("nack_idle_busy", busy, 0);

        // start while busy is ignored, then a back-to-back frame from o_done
        start_frame($urandom, 3'($urandom_range(0, 7)), 7'h7F);
        run_to_tick(50);
        data   = ~data;
        bright = ~bright;
        start  = 1'b1;
        cycle();
        start  = 1'b0;
        check("hs_still_busy", busy, 1);
        wait_done("hs");
        start_frame($urandom, 3'($urandom_range(0, 7)), 7'h7F);
        wait_done("b2b");

        // divider stalled mid-frame
        start_frame($urandom, 3'($urandom_range(0, 7)), 7'h7F);
        run_to_tick(30);
        hold_clk = tm_clk;
        hold_oe  = dio_oe;
        div_run  = 1'b0;
        repeat (500) cycle();
        check("stall_clk", tm_clk, hold_clk);
        check("stall_oe", dio_oe, hold_oe);
        check("stall_busy", busy, 1);
        check("stall_no_ticks", tick_cnt - t0, 30);
        div_run = 1'b1;
        wait_done("stall");

        // reset in the middle of a frame
        start_frame($urandom, 3'($urandom_range(0, 7)), 7'h00);
        run_to_tick(100);
        check("pre_rst_nack", nack, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_clk", tm_clk, 1);
        check("mid_rst_oe", dio_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_nack", nack, 0);
        repeat (4) cycle();
        start_frame($urandom, 3'($urandom_range(0, 7)), 7'h7F);
        wait_done("post_rst");

        // random payloads and occasional dropped acknowledges
        for (int k = 0; k < 4; k++) begin
            logic [6:0] m;
            m = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h7F;
            repeat ($urandom_range(0, 5)) cycle();
            start_frame($urandom, 3'($urandom_range(0, 7)), m);
            wait_done($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
